address_decoder: RTL and testbench
==================================

ADDRESS_DECODER -- requirements
Module: address_decoder

Interface
REQ-001 Parameter BOOT_CYCLES, default 4, number of completed bus cycles during which ROM is overlaid at address 0.
REQ-002 Parameter RESET_CYCLES, default 16, clocks o_RESET_n/o_HALT_n stay low after i_RST_n deasserts.
REQ-003 Parameter DUART_IPL, default 3'd4, interrupt level acknowledged by o_DUIACK_n.
REQ-004 i_CLK  in  1  single system clock; all state on its rising edge.
REQ-005 i_RST_n  in  1  asynchronous, active-low reset.
REQ-006 i_A  in  6  CPU address A[23:18].
REQ-007 i_A_LOW  in  3  CPU address A[3:1], the interrupt level during IACK.
REQ-008 i_FC  in  3  CPU function code.
REQ-009 i_AS_n, i_UDS_n, i_LDS_n, i_RW  in  1 each  68000 address strobe, upper/lower data strobes, read(1)/write(0).
REQ-010 i_LGEXP_n  in  1  low = large expansion board fitted.
REQ-011 o_RESET_n, o_HALT_n  out  1 each  open-drain: drive 0 or Z, never 1; external pull-ups.
REQ-012 o_BOOT, o_RUNLED  out  1 each  boot overlay active; run indicator.
REQ-013 o_CPUSP_n, o_DUIACK_n  out  1 each  CPU-space cycle; DUART interrupt acknowledge.
REQ-014 o_DTACK_n, o_WR  out  1 each  data acknowledge; write enable.
REQ-015 o_EVENRAM_n, o_ODDRAM_n, o_EVENROM_n, o_ODDROM_n, o_IOSEL_n, o_EXPSEL_n  out  1 each  active-low chip selects.

Function
REQ-016 Address decode is combinational on i_A[23:18]: RAM = A[23:20]==0000; ROM = A[23:20]==1110; IO = A[23:19]==11111; EXP = A[23:20]==1111 and A19==0, plus 0001..1101 when i_LGEXP_n==0.
REQ-017 o_CPUSP_n shall be 0 exactly when i_FC==3'b111, combinationally; all memory/IO/EXP selects shall be 1 while o_CPUSP_n==0.
REQ-018 No select, o_DTACK_n or o_DUIACK_n shall assert while i_AS_n==1.
REQ-019 While o_BOOT==1, RAM-range read cycles select ROM instead of RAM; RAM-range write cycles still select RAM.
REQ-020 Even selects assert on i_UDS_n==0; odd selects on i_LDS_n==0; both strobes low assert both.
REQ-021 o_WR = ~i_RW when i_AS_n==0, else 0.
REQ-022 o_DTACK_n = 0 when i_AS_n==0 and a RAM or ROM select is active; else 1; IO and EXP supply their own acknowledge.
REQ-023 o_DUIACK_n = 0 when i_AS_n==0, i_FC==111, i_A[19]==1 and i_A_LOW==DUART_IPL; else 1.
REQ-024 i_AS_n shall pass through a 2-flop synchronizer; a synchronized 0->1 transition counts one completed bus cycle.
REQ-025 o_BOOT clears on the clock where the count reaches BOOT_CYCLES and stays 0 until next reset; the counter saturates.
REQ-026 Cycles completing while o_RESET_n is still driven low shall not be counted.
REQ-027 o_RUNLED = 1 when o_RESET_n released and o_BOOT==0.

Reset
REQ-028 While i_RST_n==0: o_RESET_n=0, o_HALT_n=0, o_BOOT=1, o_RUNLED=0, counters and synchronizer cleared to idle (AS high).
REQ-029 After i_RST_n rises, o_RESET_n/o_HALT_n go Z after exactly RESET_CYCLES clocks; reassertion of i_RST_n mid-boot restarts the full sequence.

Configuration
REQ-030 Macro ADDRDEC_LGEXP_EN: defined -> i_LGEXP_n honoured per REQ-016; undefined -> port present but ignored, o_EXPSEL_n decodes only 0xF00000-0xF7FFFF.

Structure
REQ-031 Shared package addr_dec_pkg holds region nibble constants, FC_CPU_SPACE, default BOOT_CYCLES/RESET_CYCLES/DUART_IPL.
REQ-032 Reset stretch, AS synchronizer and boot counter live in one sub-module reset_boot_seq; decode stays in the top.

Verification
REQ-033 Reset then hold i_AS_n=1 -> o_RESET_n/o_HALT_n low for 16 clocks then Z, o_BOOT=1, o_RUNLED=0.
REQ-034 After release, toggle i_AS_n four times -> o_BOOT=0 and o_RUNLED=1 after 4th rising edge plus synchronizer latency; third edge leaves o_BOOT=1.
REQ-035 Boot, read A=6'b000010, LDS_n=0, UDS_n=1, AS_n=0 -> o_ODDROM_n=0, o_ODDRAM_n=1, o_DTACK_n=0, o_WR=0; after boot same cycle -> o_ODDRAM_n=0, ROM selects 1.
REQ-036 Post-boot write A=6'b000010, UDS_n=0, LDS_n=1, RW=0, AS_n=0 -> o_WR=1, o_EVENRAM_n=0, others 1; AS_n=1 -> all selects 1, o_WR=0.
REQ-037 FC=111, A19=1, A_LOW=100, AS_n=0 -> o_CPUSP_n=0, o_DUIACK_n=0, all selects 1; A_LOW=011 -> o_DUIACK_n=1.
REQ-038 A=6'b111110 -> o_IOSEL_n=0, o_DTACK_n=1; A=6'b010000 with i_LGEXP_n=0 -> o_EXPSEL_n=0 (macro defined), 1 (macro undefined).

Source files
------------

// File: rtl/address_decoder_pkg.sv
// Shared constants for the 68000 address decoder: region nibbles, CPU-space
// function code and default sequencing parameters.
package addr_dec_pkg;

    localparam logic [3:0] NIB_RAM      = 4'h0;
    localparam logic [3:0] NIB_ROM      = 4'hE;
    localparam logic [3:0] NIB_IOEXP    = 4'hF;
    localparam logic [3:0] NIB_LGEXP_LO = 4'h1;
    localparam logic [3:0] NIB_LGEXP_HI = 4'hD;

    localparam logic [2:0] FC_CPU_SPACE = 3'b111;

    localparam int         BOOT_CYCLES_DEF  = 4;
    localparam int         RESET_CYCLES_DEF = 16;
    localparam logic [2:0] DUART_IPL_DEF    = 3'd4;

    typedef struct packed {
        logic ram;
        logic rom;
        logic io;
        logic exp;
    } region_t;

    // A[23:20] selects the region; A19 splits the top nibble into EXP and IO.
    function automatic region_t decode_region(input logic [5:0] a, input logic lgexp);
        region_t r;
        logic [3:0] nib;
        nib   = a[5:2];
        r.ram = (nib == NIB_RAM);
        r.rom = (nib == NIB_ROM);
        r.io  = (nib == NIB_IOEXP) & a[1];
        r.exp = ((nib == NIB_IOEXP) & ~a[1]) |
                (lgexp & (nib >= NIB_LGEXP_LO) & (nib <= NIB_LGEXP_HI));
        return r;
    endfunction

endpackage

// File: rtl/address_decoder_reset_boot_seq.sv
// Reset stretcher, address-strobe synchronizer and boot-overlay cycle counter.
module reset_boot_seq
    import addr_dec_pkg::*;
#(
    parameter int RESET_CYCLES = RESET_CYCLES_DEF,
    parameter int BOOT_CYCLES  = BOOT_CYCLES_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_as_n,
    output logic o_reset_hold,
    output logic o_boot,
    output logic o_runled
);

    localparam int RCW = $clog2(RESET_CYCLES + 1);
    localparam int BCW = $clog2(BOOT_CYCLES + 1);
    localparam logic [RCW-1:0] RST_LAST = RCW'(RESET_CYCLES - 1);
    localparam logic [RCW-1:0] RST_ONE  = RCW'(1);
    localparam logic [BCW-1:0] BOOT_MAX = BCW'(BOOT_CYCLES);
    localparam logic [BCW-1:0] BOOT_ONE = BCW'(1);

    logic           r_hold;
    logic [RCW-1:0] r_rcnt;
    logic           r_as_meta;
    logic           r_as_sync;
    logic           r_as_prev;
    logic [BCW-1:0] r_bcnt;
    logic           r_boot;
    logic           r_runled;

    logic           w_hold_nxt;
    logic [RCW-1:0] w_rcnt_nxt;
    logic           w_edge;
    logic [BCW-1:0] w_bcnt_nxt;
    logic           w_boot_nxt;

    // Next-state logic for the reset stretch and the boot-cycle counter.
    always_comb begin
        w_hold_nxt = r_hold;
        w_rcnt_nxt = r_rcnt;
        w_bcnt_nxt = r_bcnt;
        if (r_hold) begin
            if (r_rcnt == RST_LAST) begin
                w_hold_nxt = 1'b0;
            end else begin
                w_rcnt_nxt = r_rcnt + RST_ONE;
            end
        end else begin
            w_rcnt_nxt = r_rcnt;
        end
        // Bus cycles finishing while the system is still held in reset are ignored.
        w_edge = r_as_sync & ~r_as_prev;
        if (w_edge && !r_hold && (r_bcnt != BOOT_MAX)) begin
            w_bcnt_nxt = r_bcnt + BOOT_ONE;
        end else begin
            w_bcnt_nxt = r_bcnt;
        end
        w_boot_nxt = r_boot & (w_bcnt_nxt != BOOT_MAX);
    end

    // State registers; the synchronizer idles with AS deasserted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hold    <= 1'b1;
            r_rcnt    <= '0;
            r_as_meta <= 1'b1;
            r_as_sync <= 1'b1;
            r_as_prev <= 1'b1;
            r_bcnt    <= '0;
            r_boot    <= 1'b1;
            r_runled  <= 1'b0;
        end else begin
            r_hold    <= w_hold_nxt;
            r_rcnt    <= w_rcnt_nxt;
            r_as_meta <= i_as_n;
            r_as_sync <= r_as_meta;
            r_as_prev <= r_as_sync;
            r_bcnt    <= w_bcnt_nxt;
            r_boot    <= w_boot_nxt;
            r_runled  <= ~w_hold_nxt & ~w_boot_nxt;
        end
    end

    assign o_reset_hold = r_hold;
    assign o_boot       = r_boot;
    assign o_runled     = r_runled;

endmodule

// File: rtl/address_decoder.sv
// 68000 glue: chip-select decode, DTACK/IACK generation and boot sequencing.
// Define ADDRDEC_LGEXP_EN to honour i_LGEXP_n (large expansion window).
module address_decoder
    import addr_dec_pkg::*;
#(
    parameter int         BOOT_CYCLES  = BOOT_CYCLES_DEF,
    parameter int         RESET_CYCLES = RESET_CYCLES_DEF,
    parameter logic [2:0] DUART_IPL    = DUART_IPL_DEF
) (
    input  logic       i_CLK,
    input  logic       i_RST_n,
    input  logic [5:0] i_A,
    input  logic [2:0] i_A_LOW,
    input  logic [2:0] i_FC,
    input  logic       i_AS_n,
    input  logic       i_UDS_n,
    input  logic       i_LDS_n,
    input  logic       i_RW,
    input  logic       i_LGEXP_n,
    output wire        o_RESET_n,
    output wire        o_HALT_n,
    output logic       o_BOOT,
    output logic       o_RUNLED,
    output logic       o_CPUSP_n,
    output logic       o_DUIACK_n,
    output logic       o_DTACK_n,
    output logic       o_WR,
    output logic       o_EVENRAM_n,
    output logic       o_ODDRAM_n,
    output logic       o_EVENROM_n,
    output logic       o_ODDROM_n,
    output logic       o_IOSEL_n,
    output logic       o_EXPSEL_n
);

    logic    w_hold;
    logic    w_boot;
    logic    w_lgexp;
    logic    w_cpusp;
    logic    w_mem_ok;
    logic    w_overlay;
    logic    w_ram_sel;
    logic    w_rom_sel;
    logic    w_evenram;
    logic    w_oddram;
    logic    w_evenrom;
    logic    w_oddrom;
    region_t w_reg;

    reset_boot_seq #(
        .RESET_CYCLES (RESET_CYCLES),
        .BOOT_CYCLES  (BOOT_CYCLES)
    ) u_seq (
        .i_clk        (i_CLK),
        .i_rst_n      (i_RST_n),
        .i_as_n       (i_AS_n),
        .o_reset_hold (w_hold),
        .o_boot       (w_boot),
        .o_runled     (o_RUNLED)
    );

    assign o_RESET_n = w_hold ? 1'b0 : 1'bz;
    assign o_HALT_n  = w_hold ? 1'b0 : 1'bz;
    assign o_BOOT    = w_boot;

`ifdef ADDRDEC_LGEXP_EN
    assign w_lgexp = ~i_LGEXP_n;
`else
    logic w_unused_lgexp;
    assign w_unused_lgexp = i_LGEXP_n;
    assign w_lgexp        = 1'b0;
`endif

    assign w_reg    = decode_region(i_A, w_lgexp);
    assign w_cpusp  = (i_FC == FC_CPU_SPACE);
    assign w_mem_ok = ~i_AS_n & ~w_cpusp;

    // Boot overlay steers reads of the RAM window to ROM so the reset vectors come from ROM.
    assign w_overlay = w_boot & i_RW;
    assign w_ram_sel = w_mem_ok & w_reg.ram & ~w_overlay;
    assign w_rom_sel = w_mem_ok & (w_reg.rom | (w_reg.ram & w_overlay));

    assign w_evenram = w_ram_sel & ~i_UDS_n;
    assign w_oddram  = w_ram_sel & ~i_LDS_n;
    assign w_evenrom = w_rom_sel & ~i_UDS_n;
    assign w_oddrom  = w_rom_sel & ~i_LDS_n;

    assign o_CPUSP_n   = ~w_cpusp;
    assign o_EVENRAM_n = ~w_evenram;
    assign o_ODDRAM_n  = ~w_oddram;
    assign o_EVENROM_n = ~w_evenrom;
    assign o_ODDROM_n  = ~w_oddrom;
    assign o_IOSEL_n   = ~(w_mem_ok & w_reg.io);
    assign o_EXPSEL_n  = ~(w_mem_ok & w_reg.exp);
    assign o_DTACK_n   = ~(w_evenram | w_oddram | w_evenrom | w_oddrom);
    assign o_WR        = ~i_AS_n & ~i_RW;
    assign o_DUIACK_n  = ~(~i_AS_n & w_cpusp & i_A[1] & (i_A_LOW == DUART_IPL));

endmodule

// File: tb/tb_address_decoder.sv
// Randomized and directed bench for address_decoder against an address-range model.
module tb_address_decoder;

    logic       clk;
    logic       rst_n;
    logic [5:0] a;
    logic [2:0] a_low;
    logic [2:0] fc;
    logic       as_n, uds_n, lds_n, rw, lgexp_n;
    wire        w_reset_n, w_halt_n;
    logic       o_BOOT, o_RUNLED, o_CPUSP_n, o_DUIACK_n, o_DTACK_n, o_WR;
    logic       o_EVENRAM_n, o_ODDRAM_n, o_EVENROM_n, o_ODDROM_n, o_IOSEL_n, o_EXPSEL_n;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef ADDRDEC_LGEXP_EN
    localparam bit LG_EN = 1'b1;
`else
    localparam bit LG_EN = 1'b0;
`endif

    pullup (w_reset_n);
    pullup (w_halt_n);

    address_decoder dut (
        .i_CLK       (clk),
        .i_RST_n     (rst_n),
        .i_A         (a),
        .i_A_LOW     (a_low),
        .i_FC        (fc),
        .i_AS_n      (as_n),
        .i_UDS_n     (uds_n),
        .i_LDS_n     (lds_n),
        .i_RW        (rw),
        .i_LGEXP_n   (lgexp_n),
        .o_RESET_n   (w_reset_n),
        .o_HALT_n    (w_halt_n),
        .o_BOOT      (o_BOOT),
        .o_RUNLED    (o_RUNLED),
        .o_CPUSP_n   (o_CPUSP_n),
        .o_DUIACK_n  (o_DUIACK_n),
        .o_DTACK_n   (o_DTACK_n),
        .o_WR        (o_WR),
        .o_EVENRAM_n (o_EVENRAM_n),
        .o_ODDRAM_n  (o_ODDRAM_n),
        .o_EVENROM_n (o_EVENROM_n),
        .o_ODDROM_n  (o_ODDROM_n),
        .o_IOSEL_n   (o_IOSEL_n),
        .o_EXPSEL_n  (o_EXPSEL_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected {CPUSP,DUIACK,DTACK,WR,EVENRAM,ODDRAM,EVENROM,ODDROM,IOSEL,EXPSEL}, all from byte-address ranges.
    function automatic logic [9:0] model(input logic m_as_n, input logic m_uds_n, input logic m_lds_n,
                                         input logic m_rw, input logic [2:0] m_fc, input logic [2:0] m_alow,
                                         input logic [5:0] m_a, input logic m_lg_n, input logic m_boot);
        int unsigned addr;
        bit cpu, act, in_ram, in_rom, in_io, in_exp, ram_s, rom_s, er, odr, ero, oro, ack_int;
        addr   = int'(m_a) * 32'h40000;
        cpu    = (m_fc == 3'd7);
        act    = !m_as_n && !cpu;
        in_ram = addr < 32'h100000;
        in_rom = (addr >= 32'hE00000) && (addr < 32'hF00000);
        in_io  = addr >= 32'hF80000;
        in_exp = ((addr >= 32'hF00000) && (addr < 32'hF80000)) ||
                 (LG_EN && !m_lg_n && (addr >= 32'h100000) && (addr < 32'hE00000));
        ram_s  = act && in_ram && !(m_boot && m_rw);
        rom_s  = act && (in_rom || (in_ram && m_boot && m_rw));
        er     = ram_s && !m_uds_n;
        odr    = ram_s && !m_lds_n;
        ero    = rom_s && !m_uds_n;
        oro    = rom_s && !m_lds_n;
        ack_int = !m_as_n && cpu && ((addr & 32'h80000) != 0) && (m_alow == 3'd4);
        return {!cpu, !ack_int, !(er || odr || ero || oro), (!m_as_n && !m_rw),
                !er, !odr, !ero, !oro, !(act && in_io), !(act && in_exp)};
    endfunction

    function automatic logic [9:0] dut_vec();
        return {o_CPUSP_n, o_DUIACK_n, o_DTACK_n, o_WR, o_EVENRAM_n, o_ODDRAM_n,
                o_EVENROM_n, o_ODDROM_n, o_IOSEL_n, o_EXPSEL_n};
    endfunction

    task automatic apply(input string tag, input logic t_as_n, input logic t_uds_n, input logic t_lds_n,
                         input logic t_rw, input logic [2:0] t_fc, input logic [2:0] t_alow,
                         input logic [5:0] t_a, input logic t_lg_n, input logic t_boot);
        as_n = t_as_n; uds_n = t_uds_n; lds_n = t_lds_n; rw = t_rw;
        fc = t_fc; a_low = t_alow; a = t_a; lgexp_n = t_lg_n;
        #1;
        chk(tag, 32'(dut_vec()), 32'(model(t_as_n, t_uds_n, t_lds_n, t_rw, t_fc, t_alow, t_a, t_lg_n, t_boot)));
    endtask

    task automatic rand_vec(input string tag, input logic t_boot);
        logic [2:0] rfc;
        rfc = ($urandom_range(0, 3) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
        apply(tag, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              rfc, 3'($urandom), 6'($urandom), 1'($urandom), t_boot);
    endtask

    task automatic bus_cycle();
        as_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 as_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_stretch(input string tag, input bit toggle_as);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            as_n = (toggle_as && k <= 12 && ((k - 1) % 4) < 2) ? 1'b0 : 1'b1;
            @(posedge clk);
            #1;
            chk({tag, "_reset_n"}, 32'(w_reset_n), (k == 16) ? 32'd1 : 32'd0);
            if (k == 15 || k == 16) begin
                chk({tag, "_halt_n"}, 32'(w_halt_n), (k == 16) ? 32'd1 : 32'd0);
                chk({tag, "_boot"}, 32'(o_BOOT), 32'd1);
                chk({tag, "_runled"}, 32'(o_RUNLED), 32'd0);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; rw = 1'b1;
        fc = 3'd5; a = 6'd0; a_low = 3'd0; lgexp_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_reset_n", 32'(w_reset_n), 32'd0);
        chk("rst_halt_n", 32'(w_halt_n), 32'd0);
        chk("rst_boot", 32'(o_BOOT), 32'd1);
        chk("rst_runled", 32'(o_RUNLED), 32'd0);

        // Boot overlay decode while held in reset: strobe activity cannot advance the counter.
        for (int i = 0; i < 60; i++) rand_vec("boot_rand", 1'b1);
        apply("boot_rd_odd", 1'b0, 1'b1, 1'b0, 1'b1, 3'd5, 3'd0, 6'b000010, 1'b1, 1'b1);
        chk("boot_oddrom", 32'(o_ODDROM_n), 32'd0);
        chk("boot_oddram", 32'(o_ODDRAM_n), 32'd1);
        chk("boot_dtack", 32'(o_DTACK_n), 32'd0);
        apply("boot_wr_even", 1'b0, 1'b0, 1'b1, 1'b0, 3'd5, 3'd0, 6'b000010, 1'b1, 1'b1);
        chk("boot_wr_evenram", 32'(o_EVENRAM_n), 32'd0);
        as_n = 1'b1;

        // Reset stretch with three bus cycles inside it, none of which may count.
        check_stretch("stretch1", 1'b1);
        for (int i = 0; i < 3; i++) bus_cycle();
        chk("edge3_boot", 32'(o_BOOT), 32'd1);
        chk("edge3_runled", 32'(o_RUNLED), 32'd0);
        bus_cycle();
        chk("edge4_boot", 32'(o_BOOT), 32'd0);
        chk("edge4_runled", 32'(o_RUNLED), 32'd1);

        // Post-boot decode.
        apply("post_rd_odd", 1'b0, 1'b1, 1'b0, 1'b1, 3'd5, 3'd0, 6'b000010, 1'b1, 1'b0);
        chk("post_oddram", 32'(o_ODDRAM_n), 32'd0);
        chk("post_oddrom", 32'(o_ODDROM_n), 32'd1);
        apply("post_wr_even", 1'b0, 1'b0, 1'b1, 1'b0, 3'd5, 3'd0, 6'b000010, 1'b1, 1'b0);
        chk("post_wr", 32'(o_WR), 32'd1);
        chk("post_evenram", 32'(o_EVENRAM_n), 32'd0);
        apply("post_idle", 1'b1, 1'b0, 1'b1, 1'b0, 3'd5, 3'd0, 6'b000010, 1'b1, 1'b0);
        chk("post_idle_wr", 32'(o_WR), 32'd0);
        apply("duart_iack", 1'b0, 1'b1, 1'b0, 1'b1, 3'd7, 3'd4, 6'b000010, 1'b1, 1'b0);
        chk("duiack_hit", 32'(o_DUIACK_n), 32'd0);
        apply("other_iack", 1'b0, 1'b1, 1'b0, 1'b1, 3'd7, 3'd3, 6'b000010, 1'b1, 1'b0);
        chk("duiack_miss", 32'(o_DUIACK_n), 32'd1);
        apply("io_sel", 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 3'd0, 6'b111110, 1'b1, 1'b0);
        chk("io_sel_n", 32'(o_IOSEL_n), 32'd0);
        chk("io_dtack", 32'(o_DTACK_n), 32'd1);
        apply("lgexp", 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 3'd0, 6'b010000, 1'b0, 1'b0);
        chk("lgexp_sel", 32'(o_EXPSEL_n), LG_EN ? 32'd0 : 32'd1);
        for (int i = 0; i < 150; i++) begin
            rand_vec("run_rand", 1'b0);
            if ((i % 8) == 0) @(posedge clk);
        end
        #1;
        chk("run_boot_stays", 32'(o_BOOT), 32'd0);

        // Reassert reset mid-sequence: the full stretch and boot overlay restart.
        as_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst2_boot", 32'(o_BOOT), 32'd1);
        chk("rst2_runled", 32'(o_RUNLED), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("mid_reset_n", 32'(w_reset_n), 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        check_stretch("stretch2", 1'b0);
        bus_cycle();
        chk("restart_boot", 32'(o_BOOT), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
